writeback_collector: RTL and testbench
======================================

WRITEBACK_COLLECTOR -- requirements
Module: writeback_collector

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the block SHALL use exactly these two ports for clock and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  discard all in-flight entries (branch redirect).
REQ-005 issue_valid_e / issue_valid_o  in  1  instruction issued to even / odd pipe this cycle.
REQ-006 issue_rt_e / issue_rt_o  in  7  destination register.
REQ-007 issue_we_e / issue_we_o  in  1  instruction writes RT.
REQ-008 issue_lat_e / issue_lat_o  in  4  execution latency in cycles; legal range 2..7.
REQ-009 issue_unit_e / issue_unit_o  in  3  execution unit ID, carried to write-back.
REQ-010 result_e / result_o  in  128  pipe result bus; valid in the cycle before the write-back cycle.
REQ-011 issue_accept_e / issue_accept_o  out  1  issue accepted (combinational).
REQ-012 wb_valid_e / wb_valid_o  out  1  register-file write strobe.
REQ-013 wb_rt_e / wb_rt_o  out  7  register-file write address.
REQ-014 wb_unit_e / wb_unit_o  out  3  unit ID of the retiring entry.
REQ-015 wb_data_e / wb_data_o  out  128  register-file write data.
REQ-016 query_ra / query_rb / query_rc  in  7  source registers of the instruction in decode.
REQ-017 busy_ra / busy_rb / busy_rc  out  1  matching source has a pending write.
REQ-018 wb_conflict  out  1  one-cycle pulse; same-cycle write from both pipes to the same RT.
REQ-019 lat_err  out  1  one-cycle pulse; issue presented with an illegal latency.

Function
REQ-020 Each pipe SHALL hold 7 completion slots, slot k = "retires k cycles from now", k = 1..7; each slot SHALL carry {valid, rt, we, unit}.
REQ-021 Every cycle, each slot SHALL shift from k to k-1; the slot-1 entry SHALL load into the write-back output registers.
REQ-022 issue_accept_x SHALL be high iff issue_valid_x, rst_n high, flush low, latency L in 2..7, and slot L-1 will be empty after the shift.
REQ-023 For an issue accepted in cycle N, the entry SHALL be inserted into slot L-1 at the end of cycle N.
REQ-024 wb_valid_x SHALL be high in exactly cycle N+L, with wb_rt = RT and wb_unit = unit.
REQ-025 wb_data_x SHALL be result_x registered at the end of cycle N+L-1.
REQ-026 Entries with we=0 SHALL occupy their slot; wb_valid SHALL stay low for them.
REQ-027 A slot collision (issue_accept low while issue_valid is high with legal L) SHALL leave the pipe state unchanged; the issuer retries.
REQ-028 An illegal L (0, 1, or 8..15) SHALL be rejected and SHALL pulse lat_err for one cycle.
REQ-029 If wb_valid_e and wb_valid_o would both assert in the same cycle with equal wb_rt, wb_valid_e SHALL be suppressed, the odd write SHALL proceed, and wb_conflict SHALL pulse.
REQ-030 busy_rX SHALL be high iff any valid slot (k = 1..7, either pipe) has we=1 and rt == query_rX.
  - Entries already in the write-back output registers SHALL NOT count.
  - Issues accepted in the same cycle SHALL NOT count.
REQ-031 flush SHALL invalidate all slots at the end of the cycle and block issue acceptance; the write-back registered in that cycle SHALL still occur in the next cycle.
REQ-032 If flush and issue_valid are high in the same cycle, flush SHALL win and issue_accept SHALL be low.
REQ-033 The even and odd pipes SHALL be independent; both may accept in the same cycle.

Reset
REQ-034 While rst_n is low, all slots SHALL be invalid and every output SHALL be 0, including the combinational issue_accept_x.
REQ-035 Reset asserted mid-operation SHALL discard all pending entries, and no write-back SHALL follow release.
REQ-036 The first issue SHALL be acceptable in the first cycle after rst_n deasserts.

Verification
REQ-037 Even issue RT=5, L=2 in cycle 10, result_e=0xAA..AA in cycle 11 -> wb_valid_e=1, wb_rt_e=5, wb_data_e=0xAA..AA in cycle 12 only.
REQ-038 Even L=4 in cycle 0, then even L=3 in cycle 1 -> second issue_accept_e=0; retry L=3 in cycle 2 accepted and retires in cycle 5.
REQ-039 Even RT=9 L=3 and odd RT=9 L=3 in the same cycle -> only wb_valid_o in cycle N+3; wb_conflict pulses.
REQ-040 Odd RT=20 L=6 issued, query_ra=20 -> busy_ra=1 for cycles N+1..N+5 and 0 in cycle N+6.
REQ-041 flush in cycle N+2 after L=7 issues -> no wb_valid afterwards; issue in cycle N+2 rejected; issue in cycle N+3 accepted.
REQ-042 Issue L=1 -> issue_accept=0 and lat_err pulses; rst_n low mid-flight -> outputs 0 and no write-back after release.

Source files
------------

// File: rtl/writeback_collector.sv
// Dual-pipe write-back collector: per-pipe completion shift registers that time
// register-file writes, track pending destinations and arbitrate same-RT writes.
module writeback_collector (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         issue_valid_e,
    input  logic         issue_valid_o,
    input  logic [6:0]   issue_rt_e,
    input  logic [6:0]   issue_rt_o,
    input  logic         issue_we_e,
    input  logic         issue_we_o,
    input  logic [3:0]   issue_lat_e,
    input  logic [3:0]   issue_lat_o,
    input  logic [2:0]   issue_unit_e,
    input  logic [2:0]   issue_unit_o,
    input  logic [127:0] result_e,
    input  logic [127:0] result_o,
    output logic         issue_accept_e,
    output logic         issue_accept_o,
    output logic         wb_valid_e,
    output logic         wb_valid_o,
    output logic [6:0]   wb_rt_e,
    output logic [6:0]   wb_rt_o,
    output logic [2:0]   wb_unit_e,
    output logic [2:0]   wb_unit_o,
    output logic [127:0] wb_data_e,
    output logic [127:0] wb_data_o,
    input  logic [6:0]   query_ra,
    input  logic [6:0]   query_rb,
    input  logic [6:0]   query_rc,
    output logic         busy_ra,
    output logic         busy_rb,
    output logic         busy_rc,
    output logic         wb_conflict,
    output logic         lat_err
);

    // Index 0 is the even pipe, index 1 the odd pipe.
    logic [1:0]            iv_s;
    logic [1:0]            iwe_s;
    logic [1:0][6:0]       irt_s;
    logic [1:0][3:0]       ilat_s;
    logic [1:0][2:0]       iunit_s;
    logic [1:0][127:0]     ires_s;
    logic [2:0][6:0]       query_s;

    assign iv_s    = {issue_valid_o, issue_valid_e};
    assign iwe_s   = {issue_we_o, issue_we_e};
    assign irt_s   = {issue_rt_o, issue_rt_e};
    assign ilat_s  = {issue_lat_o, issue_lat_e};
    assign iunit_s = {issue_unit_o, issue_unit_e};
    assign ires_s  = {result_o, result_e};
    assign query_s = {query_rc, query_rb, query_ra};

    // Slot k holds the entry that retires k cycles from now.
    logic [1:0][7:1]       slot_v_r;
    logic [1:0][7:1]       slot_we_r;
    logic [1:0][7:1][6:0]  slot_rt_r;
    logic [1:0][7:1][2:0]  slot_unit_r;

    logic [1:0]            wb_valid_r;
    logic [1:0][6:0]       wb_rt_r;
    logic [1:0][2:0]       wb_unit_r;
    logic [1:0][127:0]     wb_data_r;
    logic                  wb_conflict_r;
    logic                  lat_err_r;

    logic [1:0]            lat_ok_s;
    logic [1:0]            accept_s;
    logic [1:0]            wr1_s;
    logic [1:0]            wb_load_s;
    logic                  conflict_s;
    logic [2:0]            busy_s;

    // Issue acceptance: an entry for latency L lands in slot L-1 after the
    // shift, which is free exactly when slot L is free now.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            lat_ok_s[p] = (ilat_s[p] >= 4'd2) && (ilat_s[p] <= 4'd7);
            accept_s[p] = 1'b0;
            if (iv_s[p] && rst_n && !flush) begin
                case (ilat_s[p])
                    4'd2:    accept_s[p] = !slot_v_r[p][2];
                    4'd3:    accept_s[p] = !slot_v_r[p][3];
                    4'd4:    accept_s[p] = !slot_v_r[p][4];
                    4'd5:    accept_s[p] = !slot_v_r[p][5];
                    4'd6:    accept_s[p] = !slot_v_r[p][6];
                    4'd7:    accept_s[p] = !slot_v_r[p][7];
                    default: accept_s[p] = 1'b0;
                endcase
            end else begin
                accept_s[p] = 1'b0;
            end
        end
    end

    // Retiring writes and same-RT arbitration; the odd pipe wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr1_s[p] = slot_v_r[p][1] & slot_we_r[p][1];
        end
        conflict_s = (&wr1_s) && (slot_rt_r[0][1] == slot_rt_r[1][1]);
        wb_load_s  = {wr1_s[1], wr1_s[0] & ~conflict_s};
    end

    // Scoreboard lookup over in-flight slots only (write-back registers excluded).
    always_comb begin
        for (int q = 0; q < 3; q++) begin
            busy_s[q] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                for (int k = 1; k <= 7; k++) begin
                    busy_s[q] = busy_s[q] | (slot_v_r[p][k] & slot_we_r[p][k] &
                                             (slot_rt_r[p][k] == query_s[q]));
                end
            end
        end
    end

    // Slot shift/insert/flush and write-back output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_r      <= '0;
            slot_we_r     <= '0;
            slot_rt_r     <= '0;
            slot_unit_r   <= '0;
            wb_valid_r    <= 2'b00;
            wb_rt_r       <= '0;
            wb_unit_r     <= '0;
            wb_data_r     <= '0;
            wb_conflict_r <= 1'b0;
            lat_err_r     <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 1; k <= 6; k++) begin
                    slot_v_r[p][k]    <= slot_v_r[p][k+1];
                    slot_we_r[p][k]   <= slot_we_r[p][k+1];
                    slot_rt_r[p][k]   <= slot_rt_r[p][k+1];
                    slot_unit_r[p][k] <= slot_unit_r[p][k+1];
                end
                slot_v_r[p][7]    <= 1'b0;
                slot_we_r[p][7]   <= 1'b0;
                slot_rt_r[p][7]   <= 7'd0;
                slot_unit_r[p][7] <= 3'd0;
                if (accept_s[p]) begin
                    for (int k = 1; k <= 6; k++) begin
                        if (ilat_s[p] == 4'(k + 1)) begin
                            slot_v_r[p][k]    <= 1'b1;
                            slot_we_r[p][k]   <= iwe_s[p];
                            slot_rt_r[p][k]   <= irt_s[p];
                            slot_unit_r[p][k] <= iunit_s[p];
                        end
                    end
                end
                if (flush) begin
                    slot_v_r[p] <= 7'd0;
                end
                wb_valid_r[p] <= wb_load_s[p];
                wb_rt_r[p]    <= wb_load_s[p] ? slot_rt_r[p][1] : 7'd0;
                wb_unit_r[p]  <= wb_load_s[p] ? slot_unit_r[p][1] : 3'd0;
                wb_data_r[p]  <= wb_load_s[p] ? ires_s[p] : 128'd0;
            end
            wb_conflict_r <= conflict_s;
            lat_err_r     <= |(iv_s & ~lat_ok_s);
        end
    end

    assign issue_accept_e = accept_s[0];
    assign issue_accept_o = accept_s[1];
    assign wb_valid_e     = wb_valid_r[0];
    assign wb_valid_o     = wb_valid_r[1];
    assign wb_rt_e        = wb_rt_r[0];
    assign wb_rt_o        = wb_rt_r[1];
    assign wb_unit_e      = wb_unit_r[0];
    assign wb_unit_o      = wb_unit_r[1];
    assign wb_data_e      = wb_data_r[0];
    assign wb_data_o      = wb_data_r[1];
    assign busy_ra        = busy_s[0];
    assign busy_rb        = busy_s[1];
    assign busy_rc        = busy_s[2];
    assign wb_conflict    = wb_conflict_r;
    assign lat_err        = lat_err_r;

endmodule

// File: tb/tb_writeback_collector.sv
// Bench for writeback_collector: directed cycle table plus random traffic,
// all checked against a retire-time based pending-write model.
module tb_writeback_collector;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [1:0]        iv;
    logic [1:0][6:0]   irt;
    logic [1:0]        iwe;
    logic [1:0][3:0]   ilat;
    logic [1:0][2:0]   iunit;
    logic [1:0][127:0] ires;
    logic [6:0]        qa, qb, qc;
    logic [1:0]        acc;
    logic [1:0]        wbv;
    logic [1:0][6:0]   wbrt;
    logic [1:0][2:0]   wbun;
    logic [1:0][127:0] wbd;
    logic              busy_a, busy_b, busy_c, conf, lerr;

    writeback_collector dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid_e(iv[0]), .issue_valid_o(iv[1]),
        .issue_rt_e(irt[0]), .issue_rt_o(irt[1]),
        .issue_we_e(iwe[0]), .issue_we_o(iwe[1]),
        .issue_lat_e(ilat[0]), .issue_lat_o(ilat[1]),
        .issue_unit_e(iunit[0]), .issue_unit_o(iunit[1]),
        .result_e(ires[0]), .result_o(ires[1]),
        .issue_accept_e(acc[0]), .issue_accept_o(acc[1]),
        .wb_valid_e(wbv[0]), .wb_valid_o(wbv[1]),
        .wb_rt_e(wbrt[0]), .wb_rt_o(wbrt[1]),
        .wb_unit_e(wbun[0]), .wb_unit_o(wbun[1]),
        .wb_data_e(wbd[0]), .wb_data_o(wbd[1]),
        .query_ra(qa), .query_rb(qb), .query_rc(qc),
        .busy_ra(busy_a), .busy_rb(busy_b), .busy_rc(busy_c),
        .wb_conflict(conf), .lat_err(lerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         pipe;
        int         retire;
        logic [6:0] rt;
        logic       we;
        logic [2:0] unit;
    } ent_t;

    typedef struct {
        bit fl;
        bit ve; int rte; bit wee; int late;
        bit vo; int rto; bit weo; int lato;
        bit ae, ao, wbe, wbo, cf, le;
    } row_t;

    ent_t              pend[$];
    logic [1:0][127:0] prev_res;
    bit                prev_le;
    int                cyc;
    int                tests;
    int                fails;
    row_t              tbl[19];
    int                wb_seen;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: an entry issued in cycle N with latency L writes back in N+L.
    task automatic check_model();
        bit         ev[2];
        logic [6:0] ert[2];
        logic [2:0] eun[2];
        bit         ecf;
        bit         legal;
        bit         eacc;
        bit         eb[3];
        bit         taken;
        logic [6:0] qs[3];
        string      sfx;
        qs = '{qa, qb, qc};
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                sfx = (p == 0) ? "_e" : "_o";
                chk({"rst_accept", sfx}, 128'(acc[p]), 128'(0));
                chk({"rst_wb_valid", sfx}, 128'(wbv[p]), 128'(0));
                chk({"rst_wb_rt", sfx}, 128'(wbrt[p]), 128'(0));
                chk({"rst_wb_data", sfx}, wbd[p], 128'(0));
            end
            chk("rst_busy", 128'({busy_a, busy_b, busy_c}), 128'(0));
            chk("rst_flags", 128'({conf, lerr}), 128'(0));
            pend.delete();
            prev_le = 1'b0;
        end else begin
            ev = '{1'b0, 1'b0};
            ert = '{7'd0, 7'd0};
            eun = '{3'd0, 3'd0};
            foreach (pend[i]) begin
                if (pend[i].retire == cyc) begin
                    ev[pend[i].pipe]  = pend[i].we;
                    ert[pend[i].pipe] = pend[i].rt;
                    eun[pend[i].pipe] = pend[i].unit;
                end
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].retire <= cyc) pend.delete(i);
            end
            ecf = ev[0] && ev[1] && (ert[0] == ert[1]);
            if (ecf) ev[0] = 1'b0;
            chk("wb_conflict", 128'(conf), 128'(ecf));
            chk("lat_err", 128'(lerr), 128'(prev_le));
            for (int p = 0; p < 2; p++) begin
                sfx = (p == 0) ? "_e" : "_o";
                chk({"wb_valid", sfx}, 128'(wbv[p]), 128'(ev[p]));
                if (ev[p]) begin
                    chk({"wb_rt", sfx}, 128'(wbrt[p]), 128'(ert[p]));
                    chk({"wb_unit", sfx}, 128'(wbun[p]), 128'(eun[p]));
                    chk({"wb_data", sfx}, wbd[p], prev_res[p]);
                end
            end
            for (int q = 0; q < 3; q++) begin
                eb[q] = 1'b0;
                foreach (pend[i]) if (pend[i].we && pend[i].rt == qs[q]) eb[q] = 1'b1;
            end
            chk("busy_ra", 128'(busy_a), 128'(eb[0]));
            chk("busy_rb", 128'(busy_b), 128'(eb[1]));
            chk("busy_rc", 128'(busy_c), 128'(eb[2]));
            prev_le = 1'b0;
            for (int p = 0; p < 2; p++) begin
                sfx = (p == 0) ? "_e" : "_o";
                legal = (ilat[p] >= 4'd2) && (ilat[p] <= 4'd7);
                taken = 1'b0;
                foreach (pend[i]) if (pend[i].pipe == p && pend[i].retire == cyc + int'(ilat[p])) taken = 1'b1;
                eacc = iv[p] && legal && !flush && !taken;
                chk({"issue_accept", sfx}, 128'(acc[p]), 128'(eacc));
                if (eacc) pend.push_back('{p, cyc + int'(ilat[p]), irt[p], iwe[p], iunit[p]});
                if (iv[p] && !legal) prev_le = 1'b1;
            end
            if (flush) begin
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (pend[i].retire >= cyc + 2) pend.delete(i);
                end
            end
            prev_res = ires;
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_model();
    endtask

    task automatic tick_adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        iv    = 2'b00;
        iwe   = 2'b00;
        irt   = '0;
        ilat  = '0;
        iunit = '0;
        ires  = {rnd128(), rnd128()};
    endtask

    task automatic apply_row(input row_t r);
        flush    = r.fl;
        iv       = {r.vo, r.ve};
        iwe      = {r.weo, r.wee};
        irt[0]   = 7'(r.rte);
        irt[1]   = 7'(r.rto);
        ilat[0]  = 4'(r.late);
        ilat[1]  = 4'(r.lato);
        iunit[0] = 3'(r.rte);
        iunit[1] = 3'(r.rto + 1);
        ires     = {rnd128(), rnd128()};
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; prev_le = 1'b0; prev_res = '0;
        rst_n = 1'b0;
        qa = 7'd20; qb = 7'd9; qc = 7'd3;
        idle_inputs();
        //            fl  ve rte we lat  vo rto we lat  ae ao wbe wbo cf le
        tbl[0]  = '{0, 1, 5, 1, 2,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 6, 1, 4,  1, 9, 1, 3,  1, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 7, 1, 3,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 7, 1, 3,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 8, 1, 1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1};
        tbl[6]  = '{0, 1, 9, 1, 3,  1, 9, 1, 3,  1, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 0};
        tbl[10] = '{0, 1, 3, 0, 2,  1, 20, 1, 6, 1, 1, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0,  1, 21, 1, 7, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 11, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 11, 1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};

        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            iv = 2'b11; ilat = {4'd3, 4'd2};
            tick_check();
            tick_adv();
        end

        // Directed table; row 0 is the first cycle after reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            apply_row(tbl[i]);
            tick_check();
            chk($sformatf("tbl%0d_accept_e", i), 128'(acc[0]), 128'(tbl[i].ae));
            chk($sformatf("tbl%0d_accept_o", i), 128'(acc[1]), 128'(tbl[i].ao));
            chk($sformatf("tbl%0d_wb_valid_e", i), 128'(wbv[0]), 128'(tbl[i].wbe));
            chk($sformatf("tbl%0d_wb_valid_o", i), 128'(wbv[1]), 128'(tbl[i].wbo));
            chk($sformatf("tbl%0d_conflict", i), 128'(conf), 128'(tbl[i].cf));
            chk($sformatf("tbl%0d_lat_err", i), 128'(lerr), 128'(tbl[i].le));
            if (i == 11 || i == 12) chk($sformatf("tbl%0d_busy_ra", i), 128'(busy_a), 128'(1));
            tick_adv();
        end

        // Reset in the middle of flight: nothing may retire after release.
        idle_inputs();
        iv = 2'b11; iwe = 2'b11; irt = {7'd31, 7'd30}; ilat = {4'd5, 4'd7};
        tick_check(); tick_adv();
        idle_inputs(); tick_check(); tick_adv();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            iv = 2'b11; ilat = {4'd4, 4'd4}; irt = {7'd30, 7'd30}; iwe = 2'b11;
            qa = 7'd30;
            tick_check();
            chk("midrst_accept", 128'(acc), 128'(0));
            chk("midrst_busy_ra", 128'(busy_a), 128'(0));
            tick_adv();
        end
        rst_n = 1'b1;
        wb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            tick_check();
            wb_seen += int'(wbv[0]) + int'(wbv[1]);
            tick_adv();
        end
        chk("midrst_no_wb_after_release", 128'(wb_seen), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < 2; p++) begin
                iv[p]    = ($urandom_range(0, 2) != 0);
                iwe[p]   = ($urandom_range(0, 4) != 0);
                irt[p]   = 7'($urandom_range(0, 15));
                ilat[p]  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(2, 7));
                iunit[p] = 3'($urandom_range(0, 7));
            end
            ires = {rnd128(), rnd128()};
            qa = 7'($urandom_range(0, 15));
            qb = 7'($urandom_range(0, 15));
            qc = 7'($urandom_range(0, 15));
            tick_check();
            tick_adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
